// File: rtl/stream_pkg.sv
// Width helpers shared by the stream FIFO and its wrap-around pointers.
package stream_pkg;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // A single-entry FIFO still needs a one-bit pointer to index its storage.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-depth pointer: counts 0..depth-1 and wraps by explicit compare.
module fifo_wrap_ptr
  import stream_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        inc_i,
  output logic [ptr_width(depth)-1:0] ptr_o
);

  localparam int PW = ptr_width(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/stream_fifo.sv
// Single-clock valid/ready FIFO of arbitrary depth with optional fall-through,
// flush and fill-level reporting.
module stream_fifo
  import stream_pkg::*;
#(
  parameter int width        = 8,
  parameter int depth        = 4,
  parameter int fall_through = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic [width-1:0]            src_data_i,
  input  logic                        src_valid_i,
  output logic                        src_ready_o,
  output logic [width-1:0]            dst_data_o,
  output logic                        dst_valid_o,
  input  logic                        dst_ready_i,
  output logic [cnt_width(depth)-1:0] usage_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int CW = cnt_width(depth);
  localparam int PW = ptr_width(depth);

  logic [width-1:0] r_mem [depth];
  logic [CW-1:0]    r_usage;
  logic [PW-1:0]    w_rptr;
  logic [PW-1:0]    w_wptr;
  logic             w_full;
  logic             w_empty;
  logic             w_blocked;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_write;
  logic             w_read;

  assign w_full    = (r_usage == CW'(depth));
  assign w_empty   = (r_usage == '0);
  assign w_blocked = flush_i || rst_i;

  // Ready looks only at the fill level, so a full FIFO refuses a push even
  // when the head is being popped in the same cycle.
  assign src_ready_o = !w_full && !w_blocked;
  assign w_bypass    = (fall_through != 0) && w_empty && src_valid_i && !w_blocked;
  assign dst_valid_o = (!w_empty && !w_blocked) || w_bypass;
  assign dst_data_o  = rst_i ? '0 : (w_bypass ? src_data_i : r_mem[w_rptr]);

  assign w_push  = src_valid_i && src_ready_o;
  assign w_pop   = dst_valid_o && dst_ready_i;
  // A bypassed item consumed in the same cycle never touches storage.
  assign w_write = w_push && !(w_bypass && dst_ready_i);
  assign w_read  = w_pop && !w_bypass;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write) begin
      r_mem[w_wptr] <= src_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_usage <= '0;
    end else begin
      case ({w_write, w_read})
        2'b10:   r_usage <= r_usage + 1'b1;
        2'b01:   r_usage <= r_usage - 1'b1;
        default: r_usage <= r_usage;
      endcase
    end
  end

  fifo_wrap_ptr #(.depth(depth)) u_wptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (w_write),
    .ptr_o (w_wptr)
  );

  fifo_wrap_ptr #(.depth(depth)) u_rptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (w_read),
    .ptr_o (w_rptr)
  );

  assign usage_o = r_usage;
  assign full_o  = w_full;
  assign empty_o = w_empty;

  // A stalled output must hold its item until taken, flushed or reset.
  assert property (@(posedge clk_i) r_usage <= CW'(depth));
  assert property (@(posedge clk_i) !(w_read && w_empty));
  assert property (@(posedge clk_i)
    (dst_valid_o && !dst_ready_i) |=>
      (rst_i || flush_i || (dst_valid_o && $stable(dst_data_o))));

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: four configurations driven in lock-step and checked
// every cycle against a shift-array reference model.
module tb_stream_fifo;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst;

  logic [NI-1:0]      srcValid;
  logic [NI-1:0]      dstReady;
  logic [NI-1:0]      flush;
  logic [NI-1:0][7:0] srcData;

  logic [NI-1:0]      srcReady;
  logic [NI-1:0]      dstValid;
  logic [NI-1:0]      fullV;
  logic [NI-1:0]      emptyV;
  logic [NI-1:0][7:0] dstData;
  logic [NI-1:0][2:0] usage;
  logic [2:0]         usage0;
  logic [1:0]         usage1;
  logic [2:0]         usage2;
  logic [0:0]         usage3;

  assign usage[0] = usage0;
  assign usage[1] = {1'b0, usage1};
  assign usage[2] = usage2;
  assign usage[3] = {2'b00, usage3};

  int   depthOf [NI] = '{4, 3, 4, 1};
  bit   ftOf    [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  logic [7:0] modelQ [NI][4];
  int         modelCnt [NI];
  bit         knownZero [NI];
  bit         accepted [NI];

  int compared   = 0;
  int mismatched = 0;

  initial forever #5 clk = ~clk;

  stream_fifo #(.width(8), .depth(4), .fall_through(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
    .src_data_i(srcData[0]), .src_valid_i(srcValid[0]), .src_ready_o(srcReady[0]),
    .dst_data_o(dstData[0]), .dst_valid_o(dstValid[0]), .dst_ready_i(dstReady[0]),
    .usage_o(usage0), .full_o(fullV[0]), .empty_o(emptyV[0])
  );

  stream_fifo #(.width(8), .depth(3), .fall_through(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
    .src_data_i(srcData[1]), .src_valid_i(srcValid[1]), .src_ready_o(srcReady[1]),
    .dst_data_o(dstData[1]), .dst_valid_o(dstValid[1]), .dst_ready_i(dstReady[1]),
    .usage_o(usage1), .full_o(fullV[1]), .empty_o(emptyV[1])
  );

  stream_fifo #(.width(8), .depth(4), .fall_through(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[2]),
    .src_data_i(srcData[2]), .src_valid_i(srcValid[2]), .src_ready_o(srcReady[2]),
    .dst_data_o(dstData[2]), .dst_valid_o(dstValid[2]), .dst_ready_i(dstReady[2]),
    .usage_o(usage2), .full_o(fullV[2]), .empty_o(emptyV[2])
  );

  stream_fifo #(.width(8), .depth(1), .fall_through(0)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[3]),
    .src_data_i(srcData[3]), .src_valid_i(srcValid[3]), .src_ready_o(srcReady[3]),
    .dst_data_o(dstData[3]), .dst_valid_o(dstValid[3]), .dst_ready_i(dstReady[3]),
    .usage_o(usage3), .full_o(fullV[3]), .empty_o(emptyV[3])
  );

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s dut%0d: observed 0x%0h, expected 0x%0h", tag, k, obs, exp);
    end
  endtask

  // Expected handshake outputs follow directly from the model's fill level.
  task automatic predict(input int k, output bit eReady, output bit eValid,
                         output bit eBypass, output logic [7:0] eData);
    bit isFull, isEmpty, blocked;
    isFull  = (modelCnt[k] == depthOf[k]);
    isEmpty = (modelCnt[k] == 0);
    blocked = rst || flush[k];
    eReady  = !isFull && !blocked;
    eBypass = ftOf[k] && isEmpty && srcValid[k] && !blocked;
    eValid  = (!isEmpty && !blocked) || eBypass;
    eData   = eBypass ? srcData[k] : modelQ[k][0];
  endtask

  task automatic checkOutput(input int k);
    bit eReady, eValid, eBypass;
    logic [7:0] eData;
    predict(k, eReady, eValid, eBypass, eData);
    check("usage",     k, 8'(usage[k]),    8'(modelCnt[k]));
    check("full",      k, 8'(fullV[k]),    8'(modelCnt[k] == depthOf[k]));
    check("empty",     k, 8'(emptyV[k]),   8'(modelCnt[k] == 0));
    check("src_ready", k, 8'(srcReady[k]), 8'(eReady));
    check("dst_valid", k, 8'(dstValid[k]), 8'(eValid));
    if (rst)
      check("dst_data_rst", k, dstData[k], 8'h00);
    else if (eValid)
      check("dst_data", k, dstData[k], eData);
    else if (knownZero[k])
      check("dst_data_clr", k, dstData[k], 8'h00);
  endtask

  task automatic updateModel(input int k);
    bit eReady, eValid, eBypass, push, pop;
    logic [7:0] eData;
    predict(k, eReady, eValid, eBypass, eData);
    push = srcValid[k] && eReady;
    pop  = eValid && dstReady[k];
    accepted[k] = push;
    if (rst) begin
      modelCnt[k]  = 0;
      knownZero[k] = 1'b1;
    end else if (flush[k]) begin
      modelCnt[k] = 0;
    end else if (!(eBypass && pop)) begin
      if (pop) begin
        for (int j = 0; j < 3; j++) modelQ[k][j] = modelQ[k][j+1];
        modelCnt[k]--;
      end
      if (push) begin
        modelQ[k][modelCnt[k]] = srcData[k];
        modelCnt[k]++;
        knownZero[k] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int k, input bit v, input logic [7:0] d,
                               input bit rdy, input bit fl);
    srcValid[k] = v;
    srcData[k]  = d;
    dstReady[k] = rdy;
    flush[k]    = fl;
  endtask

  task automatic idleAll();
    for (int k = 0; k < NI; k++) applyStimulus(k, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Inputs change on the falling edge; outputs are checked 1ns later.
  task automatic stepCycle();
    #1;
    for (int k = 0; k < NI; k++) checkOutput(k);
    @(posedge clk);
    for (int k = 0; k < NI; k++) updateModel(k);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idleAll();
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      modelCnt[k]  = 0;
      knownZero[k] = 1'b1;
      accepted[k]  = 1'b0;
      for (int j = 0; j < 4; j++) modelQ[k][j] = 8'h00;
    end
    @(negedge clk);
    stepCycle();
    rst = 1'b0;
    stepCycle();

    $display("[TB] fill to full, then drain in order");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1'b1, 8'(8'h11 * i), 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(0, 1'b1, 8'h55, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(0, 1'b1, 8'h55, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
      stepCycle();
    end

    $display("[TB] depth-3 streaming with wrap");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1'b1, 8'(i), 1'b1, 1'b0);
      stepCycle();
    end
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    stepCycle();

    $display("[TB] fall-through bypass");
    applyStimulus(2, 1'b1, 8'hA5, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(2, 1'b1, 8'hA5, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(2, 1'b0, 8'h00, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(2, 1'b0, 8'h00, 1'b1, 1'b0);
    stepCycle();

    $display("[TB] flush with pending source");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(0, 1'b1, 8'h77, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(0, 1'b1, 8'h5A, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    stepCycle();
    stepCycle();

    $display("[TB] reset overrides flush");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      stepCycle();
    end
    applyStimulus(0, 1'b1, 8'hEE, 1'b1, 1'b1);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    idleAll();
    stepCycle();

    $display("[TB] depth-1 alternation");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3, 1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
      if (accepted[3] || i == 0) srcData[3] = 8'(8'h60 + i);
      stepCycle();
    end
    idleAll();
    stepCycle();

    $display("[TB] randomized traffic");
    for (int k = 0; k < NI; k++) accepted[k] = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NI; k++) begin
        if (!(srcValid[k] && !accepted[k])) begin
          srcValid[k] = ($urandom_range(0, 99) < 60);
          srcData[k]  = 8'($urandom);
        end
        dstReady[k] = ($urandom_range(0, 99) < 50);
        flush[k]    = ($urandom_range(0, 99) < 3);
      end
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
